pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
Parametrised program counter for the microcontroller datapath, extending the plain increment-only PC. It supports increment, absolute jump, signed relative branch, and subroutine call/return through an internal return-address stack of configurable depth. Sits between the instruction decoder (command strobes) and instruction memory (q drives the fetch address).

Parameters:
WIDTH, 16, bit width of PC, addresses and stack entries
STACK_DEPTH, 8, number of return-address entries (>=2)
RESET_VECTOR, 0, value loaded into q on reset
STEP, 1, amount added on increment and pushed as return offset on call

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
increment  input  1  advance PC by STEP
load  input  1  absolute jump: q <= target
call  input  1  push q+STEP, then q <= target
ret  input  1  pop top of stack into q
branch  input  1  relative branch: q <= q + offset
target  input  WIDTH  absolute address for load/call
offset  input  WIDTH  two's-complement displacement for branch
clear_err  input  1  clears sticky error flags
q  output  WIDTH  current program counter
sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  output  1  sp == STACK_DEPTH
stack_empty  output  1  sp == 0
overflow_err  output  1  sticky: call attempted while full
underflow_err  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (reset low, asynchronous): q=RESET_VECTOR, sp=0, stack_empty=1, stack_full=0, both error flags=0. Stack contents are don't-care. Release is synchronous to the next clk edge; that edge obeys the normal command rules.
- All updates occur on the rising clk edge. Results are visible on q one cycle after the command is sampled. No combinational path exists from inputs to q.
- Command priority when several strobes are high: load > call > ret > branch > increment > hold. Only the winning command executes. Lower commands are ignored and never set error flags.
- load: q <= target. Stack is untouched.
- call, not full: stack[sp] <= q+STEP, sp <= sp+1, q <= target.
- call, full: no push, q holds, sp holds, overflow_err <= 1.
- ret, not empty: q <= stack[sp-1], sp <= sp-1.
- ret, empty: q holds, underflow_err <= 1.
- branch: q <= q + offset, with offset treated as signed.
- increment: q <= q + STEP.
- No strobe: q holds.
- Arithmetic is modulo 2^WIDTH. q+STEP and q+offset wrap silently (e.g. all-ones + 1 = 0). The pushed return address wraps the same way.
- stack_full and stack_empty are decoded from sp registers (no extra latency).
- Error flags are sticky until clear_err or reset. If clear_err and a new error event occur in the same cycle, the flag remains set (set wins).
- Reset asserted mid-sequence discards all pending stack state immediately.

Test Plan:
1. Reset with WIDTH=16, RESET_VECTOR=0x0100, then release and pulse increment 3 cycles -> q=0x0100, then 0x0101, 0x0102, 0x0103; sp=0, stack_empty=1.
2. From q=0x0010: call target=0x0200, then increment x2, then ret -> q=0x0200, 0x0201, 0x0202, then 0x0011; sp goes 1 then 0.
3. STACK_DEPTH=8: perform 8 nested calls, then a 9th call with target=0x0900 -> stack_full=1 after the 8th; 9th leaves q and sp=8 unchanged and sets overflow_err=1; then 8 rets unwind the return addresses in LIFO order.
4. ret with stack empty at q=0x0050 -> q stays 0x0050, underflow_err=1. Pulse clear_err -> flag clears next cycle. clear_err together with another empty ret -> flag stays 1.
5. q=0xFFFF with increment -> q=0x0000. q=0x0005 with branch offset=0xFFFA (-6) -> q=0xFFFF. q=0x0100 with branch offset=0x0020 -> q=0x0120.
6. load, call, ret and increment all high with target=0x0AAA -> q=0x0AAA, sp unchanged. Assert reset mid-cycle with sp=3 -> q=RESET_VECTOR and sp=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment, jump, relative branch and
// call/return through an internal return-address stack with sticky error flags.
module pc_stack_unit #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STEP = 1,
  localparam int SPW = $clog2(STACK_DEPTH + 1),
  localparam int IW = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             increment_i,
  input  logic             load_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] offset_i,
  input  logic             clear_err_i,
  output logic [WIDTH-1:0] q_o,
  output logic [SPW-1:0]   sp_o,
  output logic             stack_full_o,
  output logic             stack_empty_o,
  output logic             overflow_err_o,
  output logic             underflow_err_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic [SPW-1:0]   sp_q, sp_d, top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, do_call, do_ret, push, pop;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  always_comb begin
    full    = sp_q == SPW'(STACK_DEPTH);
    empty   = sp_q == '0;
    top     = sp_q - 1'b1;
    do_call = !load_i && call_i;
    do_ret  = !load_i && !call_i && ret_i;
    push    = do_call && !full;
    pop     = do_ret && !empty;
    // Blocked call/ret still win priority, so they hold q rather than fall through.
    q_d = (load_i || push) ? target_i :
          pop ? stack_q[top[IW-1:0]] :
          (do_call || do_ret) ? q_q :
          branch_i ? q_q + offset_i :
          increment_i ? q_q + WIDTH'(STEP) : q_q;
    sp_d  = push ? sp_q + 1'b1 : pop ? top : sp_q;
    ovf_d = (do_call && full) || (ovf_q && !clear_err_i);
    unf_d = (do_ret && empty) || (unf_q && !clear_err_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RESET_VECTOR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IW-1:0]] <= q_q + WIDTH'(STEP);
  end
  assign q_o             = q_q;
  assign sp_o            = sp_q;
  assign stack_full_o    = full;
  assign stack_empty_o   = empty;
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and random checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;
  localparam int W = 16, D = 8;
  localparam logic [15:0] RV = 16'h0100;
  logic clk = 0, rst_n = 0;
  logic inc = 0, ld = 0, cl = 0, rt = 0, br = 0, clr = 0;
  logic [15:0] tgt = 0, off = 0;
  logic [15:0] q;
  logic [3:0] sp;
  logic full, empty, ovf, unf;
  int checks = 0, failures = 0;
  logic [15:0] mq;
  logic [15:0] mstk [$];
  logic mo, mu;

  pc_stack_unit #(.WIDTH(W), .STACK_DEPTH(D), .RESET_VECTOR(RV), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .increment_i(inc), .load_i(ld), .call_i(cl), .ret_i(rt),
    .branch_i(br), .target_i(tgt), .offset_i(off), .clear_err_i(clr), .q_o(q), .sp_o(sp),
    .stack_full_o(full), .stack_empty_o(empty), .overflow_err_o(ovf), .underflow_err_o(unf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".sp"}, 32'(sp), 32'(mstk.size()));
    chk({tag, ".full"}, 32'(full), 32'(mstk.size() == D));
    chk({tag, ".empty"}, 32'(empty), 32'(mstk.size() == 0));
    chk({tag, ".ovf"}, 32'(ovf), 32'(mo));
    chk({tag, ".unf"}, 32'(unf), 32'(mu));
  endtask

  task automatic model_reset();
    mq = RV; mstk.delete(); mo = 0; mu = 0;
  endtask

  // One clock with the given strobes; the model applies the priority rules directly.
  task automatic cyc(input string tag, input logic l, c, r, b, i, e, input logic [15:0] t, o);
    logic eo, eu;
    @(negedge clk);
    ld = l; cl = c; rt = r; br = b; inc = i; clr = e; tgt = t; off = o;
    eo = 0; eu = 0;
    if (l) mq = t;
    else if (c) begin
      if (mstk.size() == D) eo = 1;
      else begin mstk.push_back(mq + 16'd1); mq = t; end
    end else if (r) begin
      if (mstk.size() == 0) eu = 1;
      else mq = mstk.pop_back();
    end else if (b) mq = mq + o;
    else if (i) mq = mq + 16'd1;
    mo = eo | (mo & ~e);
    mu = eu | (mu & ~e);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk) rst_n = 1;
    // Test 1: increments from reset vector
    for (int k = 0; k < 3; k++) cyc("inc", 0, 0, 0, 0, 1, 0, 0, 0);
    // Test 2: call / ret
    cyc("ld10", 1, 0, 0, 0, 0, 0, 16'h0010, 0);
    cyc("call", 0, 1, 0, 0, 0, 0, 16'h0200, 0);
    cyc("inc1", 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("inc2", 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("ret", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("ret_addr", 32'(q), 32'h0011);
    // Test 3: fill stack, overflow, unwind
    for (int k = 0; k < D; k++) cyc("nest", 0, 1, 0, 0, 0, 0, 16'h1000 + 16'(k * 16), 0);
    chk("full_after8", 32'(full), 1);
    cyc("call9", 0, 1, 0, 0, 0, 0, 16'h0900, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("sp_held", 32'(sp), 8);
    for (int k = 0; k < D; k++) cyc("unwind", 0, 0, 1, 0, 0, 0, 0, 0);
    // Test 4: underflow and clear
    cyc("ld50", 1, 0, 0, 0, 0, 1, 16'h0050, 0);
    cyc("ret_empty", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("unf_set", 32'(unf), 1);
    chk("q_held", 32'(q), 32'h0050);
    cyc("clear", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("unf_clr", 32'(unf), 0);
    cyc("ret_empty2", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("clr_and_err", 0, 0, 1, 0, 0, 1, 0, 0);
    chk("set_wins", 32'(unf), 1);
    // Test 5: wrap and signed branch
    cyc("ldffff", 1, 0, 0, 0, 0, 1, 16'hFFFF, 0);
    cyc("wrap", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("wrap0", 32'(q), 0);
    cyc("ld5", 1, 0, 0, 0, 0, 0, 16'h0005, 0);
    cyc("brneg", 0, 0, 0, 1, 0, 0, 0, 16'hFFFA);
    chk("brneg_q", 32'(q), 32'hFFFF);
    cyc("ld100", 1, 0, 0, 0, 0, 0, 16'h0100, 0);
    cyc("brpos", 0, 0, 0, 1, 0, 0, 0, 16'h0020);
    chk("brpos_q", 32'(q), 32'h0120);
    // Test 6: priority and async reset mid-sequence
    cyc("prio", 1, 1, 1, 0, 1, 0, 16'h0AAA, 0);
    chk("prio_q", 32'(q), 32'h0AAA);
    cyc("callret_prio", 0, 1, 1, 1, 1, 0, 16'h0777, 16'h0003);
    for (int k = 0; k < 2; k++) cyc("c3", 0, 1, 0, 0, 0, 0, 16'h0300 + 16'(k), 0);
    chk("sp3", 32'(sp), 3);
    @(negedge clk);
    ld = 0; cl = 0; rt = 0; br = 0; inc = 0; clr = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk) rst_n = 1;
    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] s;
      s = 5'($urandom);
      cyc("rand", ($urandom_range(0, 9) == 0), s[0] & s[1], s[2] & s[3] | ($urandom_range(0, 5) == 0),
          s[4] & ~s[0], $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
          16'($urandom), 16'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
